// File: rtl/hyperbus_target_pkg.sv
// Shared definitions for the HyperBus responder: FSM states, CA field
// positions, register addresses and the register-select decode.
package hyperbus_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LATENCY,
    ST_RD_DATA,
    ST_WR_DATA
  } state_e;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_ID0,
    REG_CR0
  } reg_sel_e;

  localparam int unsigned CA_RW = 47;
  localparam int unsigned CA_AS = 46;
  localparam int unsigned CA_BT = 45;

  localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;
  localparam logic [31:0] REG_CR0_ADDR = 32'h0000_0800;
  localparam logic [15:0] CR0_RESET    = 16'h8F1F;

  function automatic reg_sel_e decode_reg(input logic [31:0] waddr);
    if (waddr == REG_ID0_ADDR)      return REG_ID0;
    else if (waddr == REG_CR0_ADDR) return REG_CR0;
    else                            return REG_NONE;
  endfunction

endpackage

// File: rtl/hyperbus_target_mem.sv
// 16-bit single-port synchronous RAM with per-byte write enables and a
// one-cycle registered read.
module hyperbus_target_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [0:(1 << ADDR_W) - 1];

  always_ff @(posedge clk_i) begin
    if (we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_i && be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus device-side responder: oversamples the bus on clk, decodes the
// 48-bit CA, applies latency and serves word reads/writes from RAM/registers.
import hyperbus_target_pkg::*;

module hyperbus_target #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LAT_CLKS = 6,
  parameter bit          FIXED_2X = 1'b1,
  parameter logic [15:0] ID0_VAL  = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hb_ck,
  input  logic       hb_cs_l,
  input  logic       hb_rst_l,
  input  logic [7:0] hb_dq_in,
  output logic [7:0] hb_dq_out,
  output logic       hb_dq_oe,
  input  logic       hb_rwds_in,
  output logic       hb_rwds_out,
  output logic       hb_rwds_oe,
  output logic       busy
);

  localparam logic [15:0] LAT_EDGES = 16'(2 * LAT_CLKS * (FIXED_2X ? 2 : 1));

  // two-stage input registers
  logic [1:0] ck_s_q, cs_s_q, rst_s_q, rwds_s_q;
  logic [7:0] dq_s1_q, dq_s2_q;
  logic       ck_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ck_s_q    <= '0;
      cs_s_q    <= '1;
      rst_s_q   <= '1;
      rwds_s_q  <= '0;
      dq_s1_q   <= '0;
      dq_s2_q   <= '0;
      ck_prev_q <= 1'b0;
    end else begin
      ck_s_q    <= {ck_s_q[0], hb_ck};
      cs_s_q    <= {cs_s_q[0], hb_cs_l};
      rst_s_q   <= {rst_s_q[0], hb_rst_l};
      rwds_s_q  <= {rwds_s_q[0], hb_rwds_in};
      dq_s1_q   <= hb_dq_in;
      dq_s2_q   <= dq_s1_q;
      ck_prev_q <= ck_s_q[1];
    end
  end

  logic       edge_w, cs_w, soft_rst_w, rwds_w;
  logic [7:0] dq_w;

  assign edge_w     = ck_s_q[1] != ck_prev_q;
  assign cs_w       = cs_s_q[1];
  assign rwds_w     = rwds_s_q[1];
  assign dq_w       = dq_s2_q;
  assign soft_rst_w = reset || !rst_s_q[1];

  state_e            state_q, state_d;
  reg_sel_e          reg_sel_q, reg_sel_d;
  logic [39:0]       ca_q, ca_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [15:0]       lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d, is_reg_q, is_reg_d, par_q, par_d;
  logic [7:0]        hi_q, hi_d;
  logic              hmask_q, hmask_d;
  logic [15:0]       cr0_q, cr0_d;
  logic [7:0]        dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d, rwds_out_q, rwds_out_d, rwds_oe_q, rwds_oe_d;

  logic        mem_we;
  logic [15:0] mem_rdata, rd_word_w;
  logic [47:0] ca_w;
  logic [31:0] ca_addr_w;
  logic        unused_ca;

  // The CA shift register holds the first five bytes; the sixth is taken
  // straight from the bus so decode happens on the 6th edge itself.
  assign ca_w      = {ca_q, dq_w};
  assign ca_addr_w = {ca_w[44:16], ca_w[2:0]};
  assign unused_ca = ^{ca_w[CA_BT], ca_w[15:3]};

  always_comb begin
    unique case (reg_sel_q)
      REG_ID0: rd_word_w = is_reg_q ? ID0_VAL : mem_rdata;
      REG_CR0: rd_word_w = is_reg_q ? cr0_q : mem_rdata;
      default: rd_word_w = is_reg_q ? 16'h0000 : mem_rdata;
    endcase
  end

  hyperbus_target_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i   (clk),
    .addr_i  (addr_q),
    .we_i    (mem_we),
    .be_i    (~{hmask_q, rwds_w}),
    .wdata_i ({hi_q, dq_w}),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    reg_sel_d  = reg_sel_q;
    ca_d       = ca_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    is_reg_d   = is_reg_q;
    par_d      = par_q;
    hi_d       = hi_q;
    hmask_d    = hmask_q;
    cr0_d      = cr0_q;
    dq_out_d   = dq_out_q;
    dq_oe_d    = dq_oe_q;
    rwds_out_d = rwds_out_q;
    rwds_oe_d  = rwds_oe_q;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        dq_oe_d    = 1'b0;
        dq_out_d   = '0;
        rwds_oe_d  = 1'b0;
        rwds_out_d = 1'b0;
        if (!cs_w) begin
          state_d    = ST_CA;
          cnt_d      = '0;
          rwds_oe_d  = 1'b1;
          rwds_out_d = FIXED_2X;
        end
      end
      ST_CA: if (edge_w) begin
        ca_d  = ca_w[39:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          rd_d       = ca_w[CA_RW];
          is_reg_d   = ca_w[CA_AS];
          reg_sel_d  = decode_reg(ca_addr_w);
          addr_d     = ca_addr_w[ADDR_W-1:0];
          par_d      = 1'b0;
          rwds_oe_d  = 1'b0;
          rwds_out_d = 1'b0;
          if (ca_w[CA_AS] && !ca_w[CA_RW]) begin
            state_d = ST_WR_DATA;
          end else begin
            state_d = ST_LATENCY;
            lat_d   = LAT_EDGES;
          end
        end
      end
      ST_LATENCY: if (edge_w) begin
        lat_d = lat_q - 16'd1;
        if (lat_q <= 16'd1) begin
          par_d = 1'b0;
          if (rd_q) begin
            state_d    = ST_RD_DATA;
            dq_oe_d    = 1'b1;
            dq_out_d   = rd_word_w[15:8];
            rwds_oe_d  = 1'b1;
            rwds_out_d = 1'b1;
            par_d      = 1'b1;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
      end
      // Address advances after the low byte, so the RAM has at least one
      // bus half-period to present the next word before its high byte.
      ST_RD_DATA: if (edge_w) begin
        if (par_q) begin
          dq_out_d   = rd_word_w[7:0];
          rwds_out_d = 1'b0;
          par_d      = 1'b0;
          if (!is_reg_q) addr_d = addr_q + 1'b1;
        end else begin
          dq_out_d   = rd_word_w[15:8];
          rwds_out_d = 1'b1;
          par_d      = 1'b1;
        end
      end
      ST_WR_DATA: if (edge_w) begin
        if (!par_q) begin
          hi_d    = dq_w;
          hmask_d = rwds_w;
          par_d   = 1'b1;
        end else begin
          par_d = 1'b0;
          if (is_reg_q) begin
            if (reg_sel_q == REG_CR0) cr0_d = {hi_q, dq_w};
          end else begin
            mem_we = 1'b1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cs_w) begin
      state_d   = ST_IDLE;
      dq_oe_d   = 1'b0;
      rwds_oe_d = 1'b0;
      mem_we    = 1'b0;
      cr0_d     = cr0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (soft_rst_w) begin
      state_q    <= ST_IDLE;
      reg_sel_q  <= REG_NONE;
      ca_q       <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      is_reg_q   <= 1'b0;
      par_q      <= 1'b0;
      hi_q       <= '0;
      hmask_q    <= 1'b0;
      cr0_q      <= CR0_RESET;
      dq_out_q   <= '0;
      dq_oe_q    <= 1'b0;
      rwds_out_q <= 1'b0;
      rwds_oe_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_sel_q  <= reg_sel_d;
      ca_q       <= ca_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      is_reg_q   <= is_reg_d;
      par_q      <= par_d;
      hi_q       <= hi_d;
      hmask_q    <= hmask_d;
      cr0_q      <= cr0_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      rwds_out_q <= rwds_out_d;
      rwds_oe_q  <= rwds_oe_d;
    end
  end

  assign hb_dq_out   = dq_out_q;
  assign hb_dq_oe    = dq_oe_q;
  assign hb_rwds_out = rwds_out_q;
  assign hb_rwds_oe  = rwds_oe_q;
  assign busy        = state_q != ST_IDLE;

endmodule

// File: tb/tb_hyperbus_target.sv
// Bench acting as HyperBus initiator; read bytes are checked by a monitor
// against a queue of expected {rwds, dq} values filled by the stimulus.
module tb_hyperbus_target;

  localparam int unsigned HP  = 4;
  localparam int unsigned LAT = 24;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hb_ck = 1'b0;
  logic       hb_cs_l = 1'b1;
  logic       hb_rst_l = 1'b1;
  logic [7:0] hb_dq_in = '0;
  logic       hb_rwds_in = 1'b0;
  logic [7:0] hb_dq_out;
  logic       hb_dq_oe, hb_rwds_out, hb_rwds_oe, busy;

  always #5 clk = ~clk;

  hyperbus_target #(
    .ADDR_W(10), .LAT_CLKS(6), .FIXED_2X(1'b1), .ID0_VAL(16'h0C81)
  ) dut (
    .clk(clk), .reset(reset), .hb_ck(hb_ck), .hb_cs_l(hb_cs_l),
    .hb_rst_l(hb_rst_l), .hb_dq_in(hb_dq_in), .hb_dq_out(hb_dq_out),
    .hb_dq_oe(hb_dq_oe), .hb_rwds_in(hb_rwds_in), .hb_rwds_out(hb_rwds_out),
    .hb_rwds_oe(hb_rwds_oe), .busy(busy)
  );

  typedef struct {
    logic [8:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Initiator samples the byte the target is driving at each of its own ck edges.
  always @(hb_ck) begin
    if (hb_dq_oe) begin
      if (exp_q.size() == 0) begin
        check("unexpected_byte", {7'd0, hb_rwds_out, hb_dq_out}, 16'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, {7'd0, hb_rwds_out, hb_dq_out}, {7'd0, e.v});
      end
    end
  end

  task automatic bus_edge(input logic [7:0] d, input logic r);
    hb_dq_in   = d;
    hb_rwds_in = r;
    @(negedge clk);
    hb_ck = ~hb_ck;
    repeat (HP) @(negedge clk);
  endtask

  task automatic start_ca(input logic rd, input logic rg, input logic [31:0] a);
    logic [47:0] ca;
    ca = '0;
    ca[47] = rd;
    ca[46] = rg;
    ca[44:16] = a[31:3];
    ca[2:0] = a[2:0];
    hb_cs_l = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus_edge(ca[47 - 8*i -: 8], 1'b0);
      if (i == 0) begin
        check("ca_rwds_oe", {15'd0, hb_rwds_oe}, 16'd1);
        check("ca_rwds_out", {15'd0, hb_rwds_out}, 16'd1);
        check("ca_busy", {15'd0, busy}, 16'd1);
      end
    end
    check("post_ca_rwds_oe", {15'd0, hb_rwds_oe}, 16'd0);
  endtask

  task automatic latency();
    for (int i = 0; i < LAT; i++) bus_edge(8'h00, 1'b0);
  endtask

  task automatic end_cs();
    hb_cs_l = 1'b1;
    hb_dq_in = '0;
    hb_rwds_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // m = {mask_hi, mask_lo}, shared by every word of the burst
  task automatic wr(input logic rg, input logic [31:0] a, input int n,
                    input logic [15:0] w0, input logic [15:0] w1, input logic [1:0] m);
    logic [15:0] w;
    start_ca(1'b0, rg, a);
    if (!rg) latency();
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      bus_edge(w[15:8], m[1]);
      bus_edge(w[7:0], m[0]);
    end
    end_cs();
  endtask

  task automatic rd(input logic rg, input logic [31:0] a, input int n,
                    input logic [15:0] e0, input logic [15:0] e1, input string tag);
    logic [15:0] w;
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? e0 : e1;
      exp_q.push_back('{v: {1'b1, w[15:8]}, tag: $sformatf("%s_w%0d_hi", tag, i)});
      exp_q.push_back('{v: {1'b0, w[7:0]},  tag: $sformatf("%s_w%0d_lo", tag, i)});
    end
    start_ca(1'b1, rg, a);
    latency();
    for (int i = 0; i < 2*n; i++) bus_edge(8'h00, 1'b0);
    end_cs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("rst_dq_oe", {15'd0, hb_dq_oe}, 16'd0);
    check("rst_rwds_oe", {15'd0, hb_rwds_oe}, 16'd0);
    check("rst_dq_out", {8'd0, hb_dq_out}, 16'd0);
    check("rst_rwds_out", {15'd0, hb_rwds_out}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    wr(1'b0, 32'h004, 2, 16'h1234, 16'hABCD, 2'b00);
    rd(1'b0, 32'h004, 2, 16'h1234, 16'hABCD, "readback");

    wr(1'b0, 32'h007, 1, 16'h1122, 16'h0000, 2'b00);
    wr(1'b0, 32'h007, 1, 16'hFFFF, 16'h0000, 2'b01);
    rd(1'b0, 32'h007, 1, 16'hFF22, 16'h0000, "bytemask");

    wr(1'b0, 32'h3FF, 2, 16'hCAFE, 16'hBEEF, 2'b00);
    rd(1'b0, 32'h000, 1, 16'hBEEF, 16'h0000, "wrap_wr");
    rd(1'b0, 32'h3FF, 2, 16'hCAFE, 16'hBEEF, "wrap_rd");

    rd(1'b1, 32'h000, 1, 16'h0C81, 16'h0000, "id0");
    wr(1'b1, 32'h800, 1, 16'h8F17, 16'h0000, 2'b11);
    rd(1'b1, 32'h800, 2, 16'h8F17, 16'h8F17, "cr0_burst");
    wr(1'b1, 32'h000, 1, 16'h1111, 16'h0000, 2'b00);
    rd(1'b1, 32'h000, 1, 16'h0C81, 16'h0000, "id0_ro");
    rd(1'b1, 32'h010, 1, 16'h0000, 16'h0000, "reg_other");

    hb_rst_l = 1'b0;
    repeat (4) @(negedge clk);
    hb_rst_l = 1'b1;
    repeat (4) @(negedge clk);
    rd(1'b1, 32'h800, 1, 16'h8F1F, 16'h0000, "cr0_after_rst");
    rd(1'b0, 32'h004, 1, 16'h1234, 16'h0000, "mem_kept");

    // abort a write after three data bytes
    wr(1'b0, 32'h020, 2, 16'h0101, 16'h9999, 2'b00);
    start_ca(1'b0, 1'b0, 32'h020);
    latency();
    bus_edge(8'h55, 1'b0);
    bus_edge(8'h66, 1'b0);
    bus_edge(8'h77, 1'b0);
    end_cs();
    rd(1'b0, 32'h020, 2, 16'h5566, 16'h9999, "abort_wr");

    // abort a read mid-burst
    exp_q.push_back('{v: 9'h112, tag: "abort_rd_hi"});
    exp_q.push_back('{v: 9'h034, tag: "abort_rd_lo"});
    start_ca(1'b1, 1'b0, 32'h004);
    latency();
    bus_edge(8'h00, 1'b0);
    bus_edge(8'h00, 1'b0);
    hb_cs_l = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_dq_oe", {15'd0, hb_dq_oe}, 16'd0);
    check("abort_rwds_oe", {15'd0, hb_rwds_oe}, 16'd0);
    repeat (2) @(negedge clk);
    rd(1'b0, 32'h005, 1, 16'hABCD, 16'h0000, "after_abort");

    // synchronous reset while a read is driving data
    exp_q.push_back('{v: 9'h112, tag: "rstrd_hi"});
    start_ca(1'b1, 1'b0, 32'h004);
    latency();
    bus_edge(8'h00, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("rstrd_dq_oe", {15'd0, hb_dq_oe}, 16'd0);
    check("rstrd_rwds_oe", {15'd0, hb_rwds_oe}, 16'd0);
    check("rstrd_dq_out", {8'd0, hb_dq_out}, 16'd0);
    check("rstrd_rwds_out", {15'd0, hb_rwds_out}, 16'd0);
    check("rstrd_busy", {15'd0, busy}, 16'd0);
    hb_cs_l = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    check("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
